// File: rtl/level_crossing_detector.sv
// Two-threshold hysteresis detector with dwell counting.
// Produces a debounced level, one-cycle rise/fall pulses, the peak sample of
// each active episode and a saturating count of rises.
module level_crossing_detector #(
  parameter int unsigned SIZE_DATA  = 16,
  parameter int unsigned SIZE_HOLD  = 8,
  parameter int unsigned SIZE_COUNT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [SIZE_DATA-1:0]  input_data,
  input  logic                  enable,
  input  logic [SIZE_DATA-1:0]  threshold_high,
  input  logic [SIZE_DATA-1:0]  threshold_low,
  input  logic [SIZE_HOLD-1:0]  hold_set,
  input  logic                  clear_count,
  output logic                  active,
  output logic                  rise_pulse,
  output logic                  fall_pulse,
  output logic [SIZE_DATA-1:0]  peak_data,
  output logic [SIZE_COUNT-1:0] event_count,
  output logic                  config_error
);

  localparam int unsigned HOLD_EXT_W = SIZE_HOLD + 1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RISE_PEND = 2'd1,
    S_ACTIVE    = 2'd2,
    S_FALL_PEND = 2'd3
  } state_t;

  state_t                r_state;
  logic [SIZE_HOLD-1:0]  r_cnt;
  logic                  r_active;
  logic                  r_rise;
  logic                  r_fall;
  logic [SIZE_DATA-1:0]  r_peak;
  logic [SIZE_COUNT-1:0] r_events;
  logic                  r_cfg_err;

  logic                  w_cfg_err;
  logic                  w_rise_q;
  logic                  w_fall_q;
  logic                  w_peak_gt;
  logic [HOLD_EXT_W-1:0] w_hold_eff;
  logic [HOLD_EXT_W-1:0] w_cnt_inc;
  logic                  w_first_done;
  logic                  w_cnt_done;
  logic                  w_rise_evt;
  logic                  w_cnt_sat;

  // Signed threshold compares and the effective dwell (hold of 0 acts as 1).
  assign w_cfg_err    = $signed(threshold_low) > $signed(threshold_high);
  assign w_rise_q     = $signed(input_data) >= $signed(threshold_high);
  assign w_fall_q     = $signed(input_data) <= $signed(threshold_low);
  assign w_peak_gt    = $signed(input_data) > $signed(r_peak);
  assign w_hold_eff   = (hold_set == '0) ? HOLD_EXT_W'(1) : HOLD_EXT_W'(hold_set);
  assign w_cnt_inc    = HOLD_EXT_W'(r_cnt) + HOLD_EXT_W'(1);
  assign w_first_done = (w_hold_eff == HOLD_EXT_W'(1));
  // Compared against the live hold, so lowering hold mid-count completes early.
  assign w_cnt_done   = (w_cnt_inc >= w_hold_eff);
  assign w_cnt_sat    = &r_events;

  // A rise completes on this edge: qualifying enabled sample finishing the dwell.
  assign w_rise_evt = !w_cfg_err && enable && w_rise_q &&
                      (((r_state == S_IDLE) && w_first_done) ||
                       ((r_state == S_RISE_PEND) && w_cnt_done));

  // Hysteresis FSM with dwell counter, pulses, level and peak tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_active  <= 1'b0;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
      r_peak    <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
      r_cfg_err <= w_cfg_err;
      if (w_cfg_err) begin
        // Inverted thresholds: drop out of any episode, no rise possible.
        r_state  <= S_IDLE;
        r_cnt    <= '0;
        r_active <= 1'b0;
        r_fall   <= r_active;
      end else if (enable) begin
        if (((r_state == S_ACTIVE) || (r_state == S_FALL_PEND)) && w_peak_gt) begin
          r_peak <= input_data;
        end
        case (r_state)
          S_IDLE: begin
            if (w_rise_q) begin
              if (w_first_done) begin
                r_state  <= S_ACTIVE;
                r_cnt    <= '0;
                r_active <= 1'b1;
                r_rise   <= 1'b1;
                r_peak   <= input_data;
              end else begin
                r_state <= S_RISE_PEND;
                r_cnt   <= SIZE_HOLD'(1);
              end
            end
          end
          S_RISE_PEND: begin
            if (w_rise_q) begin
              if (w_cnt_done) begin
                r_state  <= S_ACTIVE;
                r_cnt    <= '0;
                r_active <= 1'b1;
                r_rise   <= 1'b1;
                r_peak   <= input_data;
              end else begin
                r_cnt <= SIZE_HOLD'(w_cnt_inc);
              end
            end else begin
              r_state <= S_IDLE;
              r_cnt   <= '0;
            end
          end
          S_ACTIVE: begin
            if (w_fall_q) begin
              if (w_first_done) begin
                r_state  <= S_IDLE;
                r_cnt    <= '0;
                r_active <= 1'b0;
                r_fall   <= 1'b1;
              end else begin
                r_state <= S_FALL_PEND;
                r_cnt   <= SIZE_HOLD'(1);
              end
            end
          end
          S_FALL_PEND: begin
            if (w_fall_q) begin
              if (w_cnt_done) begin
                r_state  <= S_IDLE;
                r_cnt    <= '0;
                r_active <= 1'b0;
                r_fall   <= 1'b1;
              end else begin
                r_cnt <= SIZE_HOLD'(w_cnt_inc);
              end
            end else begin
              r_state <= S_ACTIVE;
              r_cnt   <= '0;
            end
          end
          default: begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_active <= 1'b0;
          end
        endcase
      end
    end
  end

  // Saturating rise counter; a coincident clear and rise leaves exactly one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_events <= '0;
    end else if (w_rise_evt) begin
      if (clear_count) begin
        r_events <= SIZE_COUNT'(1);
      end else if (!w_cnt_sat) begin
        r_events <= r_events + SIZE_COUNT'(1);
      end
    end else if (clear_count) begin
      r_events <= '0;
    end
  end

  assign active       = r_active;
  assign rise_pulse   = r_rise;
  assign fall_pulse   = r_fall;
  assign peak_data    = r_peak;
  assign event_count  = r_events;
  assign config_error = r_cfg_err;

endmodule

// File: tb/tb_level_crossing_detector.sv
// Scoreboard bench for level_crossing_detector: the driver queues the expected
// outputs for each edge, an independent monitor pops and compares them.
module tb_level_crossing_detector;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] input_data;
  logic        enable;
  logic [15:0] threshold_high;
  logic [15:0] threshold_low;
  logic [7:0]  hold_set;
  logic        clear_count;

  logic        active, rise_pulse, fall_pulse, config_error;
  logic [15:0] peak_data, event_count;
  logic        s_active, s_rise, s_fall, s_cfg;
  logic [15:0] s_peak;
  logic [1:0]  s_count;

  typedef struct {
    string       name;
    logic        a;
    logic        r;
    logic        f;
    logic [15:0] pk;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
    logic        cfg;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic exp_cfg = 1'b0;

  always #5 clk = ~clk;

  level_crossing_detector u_dut (
    .clk(clk), .reset(reset), .input_data(input_data), .enable(enable),
    .threshold_high(threshold_high), .threshold_low(threshold_low),
    .hold_set(hold_set), .clear_count(clear_count),
    .active(active), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .peak_data(peak_data), .event_count(event_count), .config_error(config_error)
  );

  level_crossing_detector #(.SIZE_COUNT(2)) u_sat (
    .clk(clk), .reset(reset), .input_data(input_data), .enable(enable),
    .threshold_high(threshold_high), .threshold_low(threshold_low),
    .hold_set(hold_set), .clear_count(clear_count),
    .active(s_active), .rise_pulse(s_rise), .fall_pulse(s_fall),
    .peak_data(s_peak), .event_count(s_count), .config_error(s_cfg)
  );

  // Drive one edge worth of inputs and queue what must be visible after it.
  task automatic step(input string name, input logic en, input int data,
                      input logic a, input logic r, input logic f,
                      input int pk, input int cnt);
    exp_t e;
    enable     = en;
    input_data = 16'(data);
    e.name = name;
    e.a    = a;
    e.r    = r;
    e.f    = f;
    e.pk   = 16'(pk);
    e.cnt  = 16'(cnt);
    e.cnt2 = (cnt > 3) ? 2'd3 : 2'(cnt);
    e.cfg  = exp_cfg;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are stable mid-cycle; compare against the oldest entry.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_tests++;
      if (active !== e.a || rise_pulse !== e.r || fall_pulse !== e.f ||
          peak_data !== e.pk || event_count !== e.cnt || config_error !== e.cfg ||
          s_count !== e.cnt2) begin
        n_fail++;
        $display("FAIL %s: got a=%0b r=%0b f=%0b peak=%0d cnt=%0d cfg=%0b sat=%0d ; want a=%0b r=%0b f=%0b peak=%0d cnt=%0d cfg=%0b sat=%0d",
                 e.name, active, rise_pulse, fall_pulse, $signed(peak_data), event_count,
                 config_error, s_count, e.a, e.r, e.f, $signed(e.pk), e.cnt, e.cfg, e.cnt2);
      end
    end
  end

  initial begin
    reset          = 1'b1;
    enable         = 1'b0;
    input_data     = '0;
    threshold_high = 16'd100;
    threshold_low  = 16'd50;
    hold_set       = 8'd3;
    clear_count    = 1'b0;

    step("reset", 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;

    // Basic rise and fall with hold 3
    step("rise_s1", 1, 120, 0, 0, 0, 0, 0);
    step("rise_s2", 1, 120, 0, 0, 0, 0, 0);
    step("rise_s3", 1, 120, 1, 1, 0, 120, 1);
    step("fall_s1", 1, 40, 1, 0, 0, 120, 1);
    step("fall_s2", 1, 40, 1, 0, 0, 120, 1);
    step("fall_s3", 1, 40, 0, 0, 1, 120, 1);
    step("idle_after_fall", 1, 40, 0, 0, 0, 120, 1);

    // Dwell aborted by an in-between sample, then restarted
    step("abort_s1", 1, 120, 0, 0, 0, 120, 1);
    step("abort_s2", 1, 120, 0, 0, 0, 120, 1);
    step("abort_mid", 1, 80, 0, 0, 0, 120, 1);
    step("restart_s1", 1, 120, 0, 0, 0, 120, 1);
    step("restart_s2", 1, 120, 0, 0, 0, 120, 1);
    step("restart_s3", 1, 120, 1, 1, 0, 120, 2);
    step("fall2_s1", 1, 40, 1, 0, 0, 120, 2);
    step("fall2_s2", 1, 40, 1, 0, 0, 120, 2);
    step("fall2_s3", 1, 40, 0, 0, 1, 120, 2);

    // Enable gaps freeze the dwell; peak tracking while active
    step("gap_s1", 1, 120, 0, 0, 0, 120, 2);
    for (int i = 0; i < 5; i++) step("gap_frozen", 0, 500, 0, 0, 0, 120, 2);
    step("gap_s2", 1, 120, 0, 0, 0, 120, 2);
    step("gap_rise", 1, 120, 1, 1, 0, 120, 3);
    step("peak_130", 1, 130, 1, 0, 0, 130, 3);
    step("peak_110", 1, 110, 1, 0, 0, 130, 3);
    step("peak_disabled", 0, 1000, 1, 0, 0, 130, 3);
    step("neg_s1", 1, -200, 1, 0, 0, 130, 3);
    step("neg_s2", 1, -200, 1, 0, 0, 130, 3);
    step("neg_fall", 1, -200, 0, 0, 1, 130, 3);

    // Hold 1: immediate transitions, saturating narrow counter
    hold_set = 8'd1;
    step("sat_rise4", 1, 120, 1, 1, 0, 120, 4);
    step("sat_fall4", 1, 40, 0, 0, 1, 120, 4);
    step("sat_rise5", 1, 120, 1, 1, 0, 120, 5);
    step("sat_fall5", 1, 40, 0, 0, 1, 120, 5);

    // Clear coincident with rise, then clear alone
    clear_count = 1'b1;
    step("clear_with_rise", 1, 120, 1, 1, 0, 120, 1);
    step("clear_alone", 1, 110, 1, 0, 0, 120, 0);
    clear_count = 1'b0;

    // Inverted thresholds while active
    threshold_low = 16'd200;
    exp_cfg = 1'b1;
    step("cfg_fall", 1, 110, 0, 0, 1, 120, 0);
    step("cfg_no_rise1", 1, 300, 0, 0, 0, 120, 0);
    step("cfg_no_rise2", 1, 300, 0, 0, 0, 120, 0);
    threshold_low = 16'd50;
    exp_cfg = 1'b0;
    step("cfg_restored_rise", 1, 300, 1, 1, 0, 300, 1);

    // Synchronous reset in FALL_PEND
    hold_set = 8'd3;
    step("fallpend", 1, 40, 1, 0, 0, 300, 1);
    reset = 1'b1;
    step("reset_fallpend", 1, 40, 0, 0, 0, 0, 0);
    reset = 1'b0;
    step("after_reset", 1, 40, 0, 0, 0, 0, 0);

    // Hold 0 behaves as 1
    hold_set = 8'd0;
    step("hold0_rise", 1, 120, 1, 1, 0, 120, 1);

    // Lowering hold mid-count completes the pending fall
    hold_set = 8'd5;
    step("hold5_s1", 1, 40, 1, 0, 0, 120, 1);
    step("hold5_s2", 1, 40, 1, 0, 0, 120, 1);
    step("hold5_s3", 1, 40, 1, 0, 0, 120, 1);
    hold_set = 8'd2;
    step("hold_lowered_fall", 1, 40, 0, 0, 1, 120, 1);

    // Equality with a threshold qualifies
    hold_set = 8'd1;
    step("eq_high_rise", 1, 100, 1, 1, 0, 100, 2);
    step("eq_low_fall", 1, 50, 0, 0, 1, 100, 2);

    enable = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expected entries never compared, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/level_crossing_detector.md
# level_crossing_detector

Downstream consumer of the moving-average stage. Takes the smoothed sample stream and its `enable` qualifier and applies two-threshold hysteresis with a programmable dwell count. It produces a debounced `active` level, single-cycle rise and fall pulses, the peak value of each active episode and a saturating event counter. It sits between the filter and the control/status register block.

## Interface
Parameters:
- `SIZE_DATA`, 16: sample width; signed two's complement; matches the moving-average output width.
- `SIZE_HOLD`, 8: width of the dwell-count setting.
- `SIZE_COUNT`, 16: width of the event counter.

Ports:
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `input_data`  in  SIZE_DATA  smoothed sample, signed.
- `enable`  in  1  sample qualifier; `input_data` is consumed only on edges where it is 1.
- `threshold_high`  in  SIZE_DATA  signed rise threshold.
- `threshold_low`  in  SIZE_DATA  signed fall threshold.
- `hold_set`  in  SIZE_HOLD  number of consecutive qualifying samples required; 0 behaves as 1.
- `clear_count`  in  1  synchronous clear of `event_count`.
- `active`  out  1  debounced level.
- `rise_pulse`  out  1  one-cycle pulse on entry to the active state.
- `fall_pulse`  out  1  one-cycle pulse on exit from the active state.
- `peak_data`  out  SIZE_DATA  maximum sample of the current or last episode.
- `event_count`  out  SIZE_COUNT  number of rises, saturating.
- `config_error`  out  1  high while `threshold_low > threshold_high`.

## Operation
- FSM states:
  - IDLE (inactive, stable)
  - RISE_PEND (inactive, counting)
  - ACTIVE (active, stable)
  - FALL_PEND (active, counting)
- Qualifying sample definitions, all signed compares:
  - rise-qualifying: `input_data >= threshold_high`
  - fall-qualifying: `input_data <= threshold_low`
- Edges with `enable=0`: FSM, dwell counter and peak are frozen.
- IDLE, enabled rise-qualifying sample: counter=1. If the effective hold is 1, go to ACTIVE; otherwise go to RISE_PEND.
- RISE_PEND, enabled sample:
  - Rise-qualifying: counter increments. When the counter reaches the effective hold, go to ACTIVE.
  - Non-qualifying: go to IDLE, counter=0.
- ACTIVE and FALL_PEND mirror IDLE and RISE_PEND, using fall-qualifying samples and exiting to IDLE.
- Samples between the two thresholds never qualify and abort any pending count.
- `active` is 1 in ACTIVE and FALL_PEND.
- On the IDLE/RISE_PEND→ACTIVE transition:
  - `rise_pulse`=1
  - `peak_data` is loaded with the completing sample
  - `event_count` increments
- While active: `peak_data` is updated on enabled samples strictly greater than the current peak. After the fall, `peak_data` holds until the next rise.
- `event_count` saturates at all-ones. `clear_count` sets it to 0. If clear and rise occur on the same edge, the result is 1.
- `hold_set` is sampled on every edge. Changing `hold_set` mid-count compares the existing count against the new value. If count ≥ new hold on a qualifying sample, the transition completes.
- While `threshold_low > threshold_high` (combinational check of the current inputs):
  - FSM is forced to IDLE and the counter to 0.
  - `fall_pulse` fires if the FSM was active.
  - No rise can occur.

## Timing
- All outputs are registered.
- On reset: FSM IDLE, counter 0, and all of `active`, `rise_pulse`, `fall_pulse`, `peak_data`, `event_count`, `config_error` are 0.
- Latency: the completing sample is sampled at edge N. `active`, `rise_pulse` or `fall_pulse`, `peak_data` and `event_count` all change at edge N, so they are visible in the cycle after N.
- Pulses are exactly one cycle wide.
- Minimum spacing between rise and fall is hold enabled samples.
- `config_error` reflects the thresholds sampled at the previous edge.
- Reset asserted mid-episode: everything returns to reset values at that edge. No `fall_pulse` is emitted.
- Reset has priority over `clear_count` and all other inputs.

## Test plan
- Basic rise/fall: high=100, low=50, hold=3. Enabled samples 120,120,120.
  - Required: `active` and `rise_pulse` rise after the 3rd sample, `event_count`=1, `peak_data`=120.
  - Then samples 40,40,40. Required: `fall_pulse` one cycle, `active`=0, `peak_data` stays 120.
- Aborted dwell: samples 120,120,80,120 with hold=3. Required: no `rise_pulse`; a new count starts at the 4th sample.
- Enable gaps and peak tracking: samples 120,(enable=0 ×5),120,120.
  - Required: rise after the 3rd enabled sample.
  - Then active samples 130,110,-200,-200,-200. Required: `peak_data`=130 and a fall after the third -200.
- Counter saturation and clear:
  - SIZE_COUNT=2 with 5 rises. Required: `event_count`=3.
  - `clear_count` coincident with a rise. Required: `event_count`=1.
- Config error: while ACTIVE, set low=200, high=100.
  - Required: `fall_pulse` and `active`=0 the next cycle, `config_error`=1, and no rise on samples of 300 until the thresholds are restored.
- Reset and hold=0:
  - Synchronous reset in FALL_PEND. Required: all outputs 0 and no pulse.
  - With hold=0, a single sample of 120. Required: immediate rise.
